// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed four-digit 7-segment scan controller with shadowed value load,
// per-slot anode guard band and optional leading-zero blanking.
//
// state | meaning
// S0    | digit 0 (rightmost) selected
// S1    | digit 1 selected
// S2    | digit 2 selected
// S3    | digit 3 selected; frame wraps at the end of this slot
module seven_seg_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    output logic [3:0]  x,
    output logic [3:0]  an,
    output logic        dp,
    output logic        pending,
    output logic        frame_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;
    localparam logic [1:0] S3 = 2'd3;

    generate
        if (REFRESH_DIV < 2) begin : g_bad_div
            $error("REFRESH_DIV must be at least 2");
        end
        if (GUARD < 0 || GUARD >= REFRESH_DIV) begin : g_bad_guard
            $error("GUARD must satisfy 0 <= GUARD < REFRESH_DIV");
        end
    endgenerate

    logic [PW-1:0] pre;
    logic [1:0]    slot;
    logic [15:0]   display;
    logic [3:0]    dp_reg;
    logic [15:0]   shadow_val;
    logic [3:0]    shadow_dp;

    logic slot_end;
    logic frame_wrap;
    logic guard_active;
    logic [3:0] lz_blank;

    assign slot_end   = (pre == PRE_LAST);
    assign frame_wrap = slot_end && (slot == S3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (slot_end) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot <= S0;
        end else if (slot_end) begin
            case (slot)
                S0:      slot <= S1;
                S1:      slot <= S2;
                S2:      slot <= S3;
                default: slot <= S0;
            endcase
        end
    end

    // A load coinciding with the frame wrap bypasses the shadow so it is not delayed a frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            display    <= '0;
            dp_reg     <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
        end else if (load && frame_wrap) begin
            display    <= value;
            dp_reg     <= dp_in;
            shadow_val <= value;
            shadow_dp  <= dp_in;
            pending    <= 1'b0;
        end else if (load) begin
            shadow_val <= value;
            shadow_dp  <= dp_in;
            pending    <= 1'b1;
        end else if (frame_wrap && pending) begin
            display    <= shadow_val;
            dp_reg     <= shadow_dp;
            pending    <= 1'b0;
        end
    end

    generate
        if (GUARD > 0) begin : g_guard
            localparam logic [PW-1:0] GUARD_LAST = PW'(GUARD);
            assign guard_active = (pre < GUARD_LAST);
        end else begin : g_no_guard
            assign guard_active = 1'b0;
        end
    endgenerate

    // Digit 0 is never blanked so a zero value still shows a single 0.
    always_comb begin
        lz_blank = 4'b0000;
        if (lz_en) begin
            lz_blank[3] = (display[15:12] == 4'h0);
            lz_blank[2] = lz_blank[3] && (display[11:8] == 4'h0);
            lz_blank[1] = lz_blank[2] && (display[7:4] == 4'h0);
        end
    end

    always_comb begin
        case (slot)
            S0:      x = display[3:0];
            S1:      x = display[7:4];
            S2:      x = display[11:8];
            default: x = display[15:12];
        endcase
    end

    always_comb begin
        an = 4'b1111;
        if (!guard_active && !lz_blank[slot]) begin
            an[slot] = 1'b0;
        end
    end

    assign dp         = an[slot] ? 1'b1 : ~dp_reg[slot];
    assign frame_tick = frame_wrap;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl (REFRESH_DIV = 8, GUARD = 2): stimulus queues
// hand-computed per-cycle expectations, a negedge monitor pops and compares them.
module tb_seven_seg_scan_ctrl;

    localparam int BASE = 3;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [3:0]  x;
    logic [3:0]  an;
    logic        dp;
    logic        pending;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    int tcyc   = 0;

    typedef struct {
        int         at;
        string      name;
        logic [3:0] an;
        logic [3:0] x;
        logic       dp;
        logic       pend;
        logic       tick;
    } exp_t;

    exp_t q[$];
    exp_t e;

    seven_seg_scan_ctrl #(
        .REFRESH_DIV(8),
        .GUARD(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .value(value),
        .dp_in(dp_in),
        .lz_en(lz_en),
        .x(x),
        .an(an),
        .dp(dp),
        .pending(pending),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) tcyc <= tcyc + 1;

    function automatic void exp_at(input int n, input string nm, input logic [3:0] a,
                                   input logic [3:0] xx, input logic d, input logic p,
                                   input logic t);
        exp_t ne;
        ne.at   = BASE + n;
        ne.name = nm;
        ne.an   = a;
        ne.x    = xx;
        ne.dp   = d;
        ne.pend = p;
        ne.tick = t;
        q.push_back(ne);
    endfunction

    task automatic chk(input string nm, input string f, input logic [3:0] got,
                       input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s %s got=%h exp=%h (cycle %0d)", nm, f, got, want, tcyc);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at < tcyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s missed got=cycle %0d exp=cycle %0d", e.name, tcyc, e.at);
        end
        while (q.size() > 0 && q[0].at == tcyc) begin
            e = q.pop_front();
            chk(e.name, "an", an, e.an);
            chk(e.name, "x", x, e.x);
            chk(e.name, "dp", {3'b000, dp}, {3'b000, e.dp});
            chk(e.name, "pending", {3'b000, pending}, {3'b000, e.pend});
            chk(e.name, "frame_tick", {3'b000, frame_tick}, {3'b000, e.tick});
        end
    end

    task automatic at_state(input int n);
        while (tcyc < BASE + n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_load(input int n, input logic [15:0] v, input logic [3:0] d);
        at_state(n);
        load  = 1'b1;
        value = v;
        dp_in = d;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        value = 16'h0000;
        dp_in = 4'h0;
        lz_en = 1'b0;

        // name, an, x, dp, pending, frame_tick
        exp_at(-2,  "rst_a",      4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
        exp_at(-1,  "rst_b",      4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
        exp_at(0,   "rst_done",   4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
        exp_at(2,   "ld_pend",    4'b1110, 4'h0, 1'b1, 1'b1, 1'b0);
        exp_at(30,  "pend_hold",  4'b0111, 4'h0, 1'b1, 1'b1, 1'b0);
        exp_at(31,  "wrap1",      4'b0111, 4'h0, 1'b1, 1'b1, 1'b1);
        exp_at(32,  "s0_guard0",  4'b1111, 4'h4, 1'b1, 1'b0, 1'b0);
        exp_at(33,  "s0_guard1",  4'b1111, 4'h4, 1'b1, 1'b0, 1'b0);
        exp_at(34,  "s0_on",      4'b1110, 4'h4, 1'b1, 1'b0, 1'b0);
        exp_at(39,  "s0_last",    4'b1110, 4'h4, 1'b1, 1'b0, 1'b0);
        exp_at(40,  "s1_guard",   4'b1111, 4'h3, 1'b1, 1'b0, 1'b0);
        exp_at(42,  "s1_on",      4'b1101, 4'h3, 1'b1, 1'b0, 1'b0);
        exp_at(48,  "s2_guard",   4'b1111, 4'h2, 1'b1, 1'b0, 1'b0);
        exp_at(50,  "s2_dp",      4'b1011, 4'h2, 1'b0, 1'b0, 1'b0);
        exp_at(58,  "s3_on",      4'b0111, 4'h1, 1'b1, 1'b0, 1'b0);
        exp_at(63,  "wrap2",      4'b0111, 4'h1, 1'b1, 1'b0, 1'b1);
        exp_at(73,  "b2b_pend",   4'b1111, 4'h3, 1'b1, 1'b1, 1'b0);
        exp_at(94,  "pre_wrap3",  4'b0111, 4'h1, 1'b1, 1'b1, 1'b0);
        exp_at(95,  "wrap3",      4'b0111, 4'h1, 1'b1, 1'b1, 1'b1);
        exp_at(96,  "beef_s0g",   4'b1111, 4'hF, 1'b1, 1'b0, 1'b0);
        exp_at(98,  "beef_s0",    4'b1110, 4'hF, 1'b0, 1'b0, 1'b0);
        exp_at(101, "ld0050",     4'b1110, 4'hF, 1'b0, 1'b1, 1'b0);
        exp_at(106, "beef_s1",    4'b1101, 4'hE, 1'b1, 1'b1, 1'b0);
        exp_at(114, "beef_s2",    4'b1011, 4'hE, 1'b1, 1'b1, 1'b0);
        exp_at(122, "beef_s3",    4'b0111, 4'hB, 1'b1, 1'b1, 1'b0);
        exp_at(127, "wrap4",      4'b0111, 4'hB, 1'b1, 1'b1, 1'b1);
        exp_at(130, "lz50_s0",    4'b1110, 4'h0, 1'b1, 1'b0, 1'b0);
        exp_at(138, "lz50_s1",    4'b1101, 4'h5, 1'b1, 1'b0, 1'b0);
        exp_at(146, "lz50_s2",    4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
        exp_at(154, "lz50_s3",    4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
        exp_at(159, "wrap5",      4'b1111, 4'h0, 1'b1, 1'b0, 1'b1);
        exp_at(171, "lz50_s1b",   4'b1101, 4'h5, 1'b1, 1'b1, 1'b0);
        exp_at(178, "lzoff_s2",   4'b1011, 4'h0, 1'b1, 1'b1, 1'b0);
        exp_at(186, "lzon_s3",    4'b1111, 4'h0, 1'b1, 1'b1, 1'b0);
        exp_at(194, "lz0_s0",     4'b1110, 4'h0, 1'b0, 1'b0, 1'b0);
        exp_at(202, "lz0_s1",     4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
        exp_at(210, "lz0_s2",     4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
        exp_at(218, "lz0_s3",     4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
        exp_at(223, "wrap7",      4'b1111, 4'h0, 1'b1, 1'b0, 1'b1);
        exp_at(242, "lz0_s2b",    4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
        exp_at(244, "midrst",     4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
        exp_at(246, "rst_s0",     4'b1110, 4'h0, 1'b1, 1'b0, 1'b0);
        exp_at(275, "rst_wrap",   4'b0111, 4'h0, 1'b1, 1'b0, 1'b1);
        exp_at(278, "rst_s0b",    4'b1110, 4'h0, 1'b1, 1'b0, 1'b0);
        exp_at(294, "rst_s2",     4'b1011, 4'h0, 1'b1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        pulse_load(1, 16'h1234, 4'b0100);
        pulse_load(70, 16'hAAAA, 4'b0000);
        pulse_load(72, 16'h1111, 4'b0000);
        pulse_load(95, 16'hBEEF, 4'b0001);
        pulse_load(100, 16'h0050, 4'b0000);
        at_state(128);
        lz_en = 1'b1;
        pulse_load(170, 16'h0000, 4'b1111);
        at_state(176);
        lz_en = 1'b0;
        at_state(180);
        lz_en = 1'b1;

        // Reset during S2 with a simultaneous load that must be discarded.
        at_state(243);
        rst_n = 1'b0;
        load  = 1'b1;
        value = 16'hFFFF;
        dp_in = 4'b1111;
        lz_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        load  = 1'b0;

        at_state(300);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got=%0d pending_expectations exp=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
